// File: rtl/broadcast_snoop_filter.sv
// Snoop filter: a fully-associative sharer table turns broadcast probes into
// targeted probes, with a release channel and a one-entry registered response.
module broadcast_snoop_filter #(
    parameter int unsigned ADDR_W    = 33,
    parameter int unsigned MSHR_W    = 2,
    parameter int unsigned CLIENTS   = 2,
    parameter int unsigned ENTRIES   = 8,
    parameter int unsigned LINE_BITS = 6
) (
    input  logic                clock,
    input  logic                reset,
    output logic                io_request_ready,
    input  logic                io_request_valid,
    input  logic [MSHR_W-1:0]   io_request_bits_mshr,
    input  logic [ADDR_W-1:0]   io_request_bits_address,
    input  logic [CLIENTS-1:0]  io_request_bits_allocOH,
    input  logic                io_request_bits_needT,
    input  logic                io_release_valid,
    input  logic [ADDR_W-1:0]   io_release_bits_address,
    input  logic [CLIENTS-1:0]  io_release_bits_clientOH,
    input  logic                io_response_ready,
    output logic                io_response_valid,
    output logic [MSHR_W-1:0]   io_response_bits_mshr,
    output logic [ADDR_W-1:0]   io_response_bits_address,
    output logic [CLIENTS-1:0]  io_response_bits_allocOH,
    output logic                io_response_bits_needT,
    output logic [CLIENTS-1:0]  io_response_bits_probe,
    output logic                io_response_bits_hit
);

    localparam int unsigned TAG_W = ADDR_W - LINE_BITS;
    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Sharer table state
    logic [ENTRIES-1:0]  ent_valid;
    logic [TAG_W-1:0]    ent_tag     [ENTRIES];
    logic [CLIENTS-1:0]  ent_sharers [ENTRIES];
    logic [IDX_W-1:0]    victim_ptr;

    // Response register
    logic                out_valid;
    logic [MSHR_W-1:0]   out_mshr;
    logic [ADDR_W-1:0]   out_address;
    logic [CLIENTS-1:0]  out_alloc;
    logic                out_need_t;
    logic [CLIENTS-1:0]  out_probe;
    logic                out_hit;

    logic [TAG_W-1:0]     req_tag;
    logic [TAG_W-1:0]     rel_tag;
    logic [LINE_BITS-1:0] unused_rel_offset;
    logic                 accept;

    logic [ENTRIES-1:0]   rel_valid;
    logic [CLIENTS-1:0]   rel_sharers [ENTRIES];
    logic [ENTRIES-1:0]   hit_vec;
    logic [IDX_W-1:0]     hit_idx;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     alloc_idx;
    logic                 hit;
    logic                 table_full;
    logic [CLIENTS-1:0]   hit_sharers;
    logic [CLIENTS-1:0]   probe;

    logic [ENTRIES-1:0]   nxt_valid;
    logic [TAG_W-1:0]     nxt_tag     [ENTRIES];
    logic [CLIENTS-1:0]   nxt_sharers [ENTRIES];
    logic [IDX_W-1:0]     nxt_victim;

    assign req_tag           = io_request_bits_address[ADDR_W-1:LINE_BITS];
    assign rel_tag           = io_release_bits_address[ADDR_W-1:LINE_BITS];
    assign unused_rel_offset = io_release_bits_address[LINE_BITS-1:0];

    assign io_request_ready = !out_valid || io_response_ready;
    assign accept           = io_request_valid && io_request_ready;

    // Release applied first so a same-cycle request sees the pruned table
    always_comb begin
        rel_valid = ent_valid;
        for (int i = 0; i < ENTRIES; i++) begin
            rel_sharers[i] = ent_sharers[i];
            if (io_release_valid && ent_valid[i] && (ent_tag[i] == rel_tag)) begin
                rel_sharers[i] = ent_sharers[i] & ~io_release_bits_clientOH;
                if ((ent_sharers[i] & ~io_release_bits_clientOH) == '0) begin
                    rel_valid[i] = 1'b0;
                end
            end
        end
    end

    // Tag lookup and lowest free slot on the post-release view
    always_comb begin
        hit_vec  = '0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_vec[i] = rel_valid[i] && (ent_tag[i] == req_tag);
            if (hit_vec[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!rel_valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign hit         = |hit_vec;
    assign table_full  = &rel_valid;
    assign hit_sharers = rel_sharers[hit_idx];
    assign alloc_idx   = table_full ? victim_ptr : free_idx;

    // A full-table miss forgets the victim's sharers, so the new line is probed broadly
    always_comb begin
        probe = '0;
        if (hit && io_request_bits_needT) begin
            probe = hit_sharers & ~io_request_bits_allocOH;
        end else if (!hit && table_full) begin
            probe = ~io_request_bits_allocOH;
        end
    end

    // Request update layered on top of the post-release table
    always_comb begin
        nxt_valid  = rel_valid;
        nxt_victim = victim_ptr;
        for (int i = 0; i < ENTRIES; i++) begin
            nxt_tag[i]     = ent_tag[i];
            nxt_sharers[i] = rel_sharers[i];
        end
        if (accept) begin
            if (hit) begin
                nxt_sharers[hit_idx] = io_request_bits_needT
                                     ? io_request_bits_allocOH
                                     : (rel_sharers[hit_idx] | io_request_bits_allocOH);
            end else begin
                nxt_valid[alloc_idx]   = 1'b1;
                nxt_tag[alloc_idx]     = req_tag;
                nxt_sharers[alloc_idx] = io_request_bits_allocOH;
                if (table_full) begin
                    nxt_victim = victim_ptr + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid   <= '0;
            victim_ptr  <= '0;
            out_valid   <= 1'b0;
            out_mshr    <= '0;
            out_address <= '0;
            out_alloc   <= '0;
            out_need_t  <= 1'b0;
            out_probe   <= '0;
            out_hit     <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_tag[i]     <= '0;
                ent_sharers[i] <= '0;
            end
        end else begin
            ent_valid  <= nxt_valid;
            victim_ptr <= nxt_victim;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_tag[i]     <= nxt_tag[i];
                ent_sharers[i] <= nxt_sharers[i];
            end
            if (accept) begin
                out_valid   <= 1'b1;
                out_mshr    <= io_request_bits_mshr;
                out_address <= io_request_bits_address;
                out_alloc   <= io_request_bits_allocOH;
                out_need_t  <= io_request_bits_needT;
                out_probe   <= probe;
                out_hit     <= hit;
            end else if (io_response_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign io_response_valid        = out_valid;
    assign io_response_bits_mshr    = out_mshr;
    assign io_response_bits_address = out_address;
    assign io_response_bits_allocOH = out_alloc;
    assign io_response_bits_needT   = out_need_t;
    assign io_response_bits_probe   = out_probe;
    assign io_response_bits_hit     = out_hit;

    // Tags are unique in the table, so at most one entry may match
    a_single_hit: assert property (@(posedge clock) disable iff (reset)
        io_request_valid |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_broadcast_snoop_filter.sv
// Randomized bench for broadcast_snoop_filter: a behavioural sharer-table model
// feeds a scoreboard queue drained by an independent response monitor.
module tb_broadcast_snoop_filter;

    localparam int unsigned ADDR_W    = 33;
    localparam int unsigned MSHR_W    = 2;
    localparam int unsigned CLIENTS   = 2;
    localparam int unsigned ENTRIES   = 8;
    localparam int unsigned LINE_BITS = 6;
    localparam int unsigned TAG_W     = ADDR_W - LINE_BITS;
    localparam int unsigned RSP_W     = MSHR_W + ADDR_W + CLIENTS + 1 + CLIENTS + 1;

    typedef logic [RSP_W-1:0] rsp_t;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                io_request_ready;
    logic                io_request_valid = 1'b0;
    logic [MSHR_W-1:0]   io_request_bits_mshr = '0;
    logic [ADDR_W-1:0]   io_request_bits_address = '0;
    logic [CLIENTS-1:0]  io_request_bits_allocOH = '0;
    logic                io_request_bits_needT = 1'b0;
    logic                io_release_valid = 1'b0;
    logic [ADDR_W-1:0]   io_release_bits_address = '0;
    logic [CLIENTS-1:0]  io_release_bits_clientOH = '0;
    logic                io_response_ready = 1'b0;
    logic                io_response_valid;
    logic [MSHR_W-1:0]   io_response_bits_mshr;
    logic [ADDR_W-1:0]   io_response_bits_address;
    logic [CLIENTS-1:0]  io_response_bits_allocOH;
    logic                io_response_bits_needT;
    logic [CLIENTS-1:0]  io_response_bits_probe;
    logic                io_response_bits_hit;

    broadcast_snoop_filter dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_request_ready         (io_request_ready),
        .io_request_valid         (io_request_valid),
        .io_request_bits_mshr     (io_request_bits_mshr),
        .io_request_bits_address  (io_request_bits_address),
        .io_request_bits_allocOH  (io_request_bits_allocOH),
        .io_request_bits_needT    (io_request_bits_needT),
        .io_release_valid         (io_release_valid),
        .io_release_bits_address  (io_release_bits_address),
        .io_release_bits_clientOH (io_release_bits_clientOH),
        .io_response_ready        (io_response_ready),
        .io_response_valid        (io_response_valid),
        .io_response_bits_mshr    (io_response_bits_mshr),
        .io_response_bits_address (io_response_bits_address),
        .io_response_bits_allocOH (io_response_bits_allocOH),
        .io_response_bits_needT   (io_response_bits_needT),
        .io_response_bits_probe   (io_response_bits_probe),
        .io_response_bits_hit     (io_response_bits_hit)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t exp_q[$];

    // Reference model: a list of (valid, tag, sharer set) lines plus a round-robin victim
    bit                 m_valid [ENTRIES];
    logic [TAG_W-1:0]   m_tag   [ENTRIES];
    logic [CLIENTS-1:0] m_sh    [ENTRIES];
    int                 m_victim;
    bit                 m_out_valid;

    function automatic void model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_sh[i]    = '0;
        end
        m_victim    = 0;
        m_out_valid = 1'b0;
    endfunction

    function automatic void model_release(input logic [ADDR_W-1:0] addr,
                                          input logic [CLIENTS-1:0] coh);
        logic [TAG_W-1:0] t;
        t = addr[ADDR_W-1:LINE_BITS];
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (m_valid[i] && m_tag[i] == t) begin
                m_sh[i] = m_sh[i] & ~coh;
                if (m_sh[i] == '0) m_valid[i] = 1'b0;
            end
        end
    endfunction

    function automatic rsp_t model_request(input logic [MSHR_W-1:0] mshr,
                                           input logic [ADDR_W-1:0] addr,
                                           input logic [CLIENTS-1:0] alloc,
                                           input bit need_t);
        logic [TAG_W-1:0]   t;
        logic [CLIENTS-1:0] pr;
        int line;
        int slot;
        t    = addr[ADDR_W-1:LINE_BITS];
        line = -1;
        slot = -1;
        pr   = '0;
        for (int i = 0; i < int'(ENTRIES); i++)
            if (m_valid[i] && m_tag[i] == t) line = i;
        if (line >= 0) begin
            if (need_t) begin
                pr          = m_sh[line] & ~alloc;
                m_sh[line]  = alloc;
            end else begin
                m_sh[line]  = m_sh[line] | alloc;
            end
            return {mshr, addr, alloc, need_t, pr, 1'b1};
        end
        for (int i = int'(ENTRIES) - 1; i >= 0; i--)
            if (!m_valid[i]) slot = i;
        if (slot < 0) begin
            slot     = m_victim;
            m_victim = (m_victim + 1) % int'(ENTRIES);
            pr       = {CLIENTS{1'b1}} & ~alloc;
        end
        m_valid[slot] = 1'b1;
        m_tag[slot]   = t;
        m_sh[slot]    = alloc;
        return {mshr, addr, alloc, need_t, pr, 1'b0};
    endfunction

    // One clock of stimulus; the model advances exactly as the DUT should at the next edge
    task automatic step(input bit rv, input logic [MSHR_W-1:0] mshr,
                        input logic [ADDR_W-1:0] addr, input logic [CLIENTS-1:0] alloc,
                        input bit need_t, input bit relv, input logic [ADDR_W-1:0] raddr,
                        input logic [CLIENTS-1:0] rcoh, input bit rready, input bit rst);
        bit   acc;
        bit   exp_rdy;
        rsp_t item;
        @(negedge clock);
        reset                    = rst;
        io_request_valid         = rv;
        io_request_bits_mshr     = mshr;
        io_request_bits_address  = addr;
        io_request_bits_allocOH  = alloc;
        io_request_bits_needT    = need_t;
        io_release_valid         = relv;
        io_release_bits_address  = raddr;
        io_release_bits_clientOH = rcoh;
        io_response_ready        = rready;
        #1;
        acc  = 1'b0;
        item = '0;
        if (!rst) begin
            exp_rdy = !m_out_valid || rready;
            n_checks++;
            if (io_request_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL request_ready: got %b want %b", io_request_ready, exp_rdy);
            end
            if (relv) model_release(raddr, rcoh);
            if (rv && exp_rdy) begin
                acc  = 1'b1;
                item = model_request(mshr, addr, alloc, need_t);
            end
        end
        @(posedge clock);
        #1;
        if (rst) begin
            exp_q.delete();
            model_reset();
        end else if (acc) begin
            exp_q.push_back(item);
            m_out_valid = 1'b1;
        end else if (rready) begin
            m_out_valid = 1'b0;
        end
    endtask

    task automatic req(input logic [ADDR_W-1:0] addr, input logic [CLIENTS-1:0] alloc,
                       input bit need_t, input bit rready);
        step(1'b1, MSHR_W'($urandom), addr, alloc, need_t, 1'b0, '0, '0, rready, 1'b0);
    endtask

    task automatic idle(input bit rready, input bit rst);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, rready, rst);
    endtask

    task automatic check_bits_zero();
        rsp_t got;
        got = {io_response_bits_mshr, io_response_bits_address, io_response_bits_allocOH,
               io_response_bits_needT, io_response_bits_probe, io_response_bits_hit};
        n_checks++;
        if (got !== '0 || io_response_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b bits=%h want valid=0 bits=0",
                     io_response_valid, got);
        end
    endtask

    // Monitor: compares presented response with the scoreboard head, pops on handshake
    initial begin
        bit   pop;
        rsp_t got;
        forever begin
            @(negedge clock);
            #2;
            pop = 1'b0;
            if (!reset) begin
                n_checks++;
                if (io_response_valid !== (exp_q.size() != 0)) begin
                    n_fail++;
                    $display("FAIL response_valid: got %b want %b", io_response_valid,
                             exp_q.size() != 0);
                end
                if (io_response_valid === 1'b1 && exp_q.size() != 0) begin
                    got = {io_response_bits_mshr, io_response_bits_address,
                           io_response_bits_allocOH, io_response_bits_needT,
                           io_response_bits_probe, io_response_bits_hit};
                    n_checks++;
                    if (got !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL response_bits: got %h want %h", got, exp_q[0]);
                    end
                    pop = io_response_ready;
                end
            end
            @(posedge clock);
            #2;
            if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    logic [TAG_W-1:0] tag_pool [12];

    initial begin
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] ra;
        model_reset();
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        check_bits_zero();

        // First allocation, then upgrade to exclusive by the other client
        req(33'h40, 2'b01, 1'b0, 1'b1);
        req(33'h40, 2'b10, 1'b1, 1'b1);
        // Release empties the line in the same cycle a request to it arrives
        step(1'b1, 2'd2, 33'h40, 2'b01, 1'b1, 1'b1, 33'h40, 2'b10, 1'b1, 1'b0);

        // Fill the table, then 9 full-table misses to walk and wrap the victim pointer
        for (int t = 2; t <= 8; t++) req(ADDR_W'(t) << LINE_BITS, 2'b01, 1'b0, 1'b1);
        for (int t = 9; t <= 17; t++) req(ADDR_W'(t) << LINE_BITS, 2'b01, 1'b0, 1'b1);
        req(33'h40, 2'b10, 1'b1, 1'b1);

        // Backpressure: hold response for several cycles, then stream back-to-back
        for (int k = 0; k < 4; k++) req(ADDR_W'(k + 3) << LINE_BITS, 2'b10, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) req(ADDR_W'(k + 20) << LINE_BITS, 2'b10, 1'b1, 1'b1);

        // Reset while a response is held; tracked lines must be forgotten
        req(ADDR_W'(12) << LINE_BITS, 2'b01, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        check_bits_zero();
        req(ADDR_W'(12) << LINE_BITS, 2'b10, 1'b1, 1'b1);
        idle(1'b1, 1'b0);

        // Randomized traffic over a small tag pool to exercise hits, releases and eviction
        for (int i = 0; i < 12; i++) tag_pool[i] = TAG_W'($urandom);
        for (int n = 0; n < 3000; n++) begin
            a  = {tag_pool[$urandom_range(0, 11)], LINE_BITS'($urandom)};
            ra = {tag_pool[$urandom_range(0, 11)], LINE_BITS'($urandom)};
            step($urandom_range(0, 9) < 8, MSHR_W'($urandom), a,
                 CLIENTS'(1 << $urandom_range(0, CLIENTS - 1)), 1'($urandom),
                 $urandom_range(0, 9) < 3, ra, CLIENTS'($urandom_range(1, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
        end

        for (int k = 0; k < 4; k++) idle(1'b1, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
